rs_alu: RTL and testbench
=========================

Name: rs_alu

Overview:
- Integer ALU reservation station, directly downstream of the register alias table at dispatch.
- Accepts a renamed instruction: op, destination ROB tag, and per source either a ready value or a pending ROB tag from the alias table.
- Snoops the CDB to capture pending operands.
- Issues the oldest fully-ready entry to the ALU over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of station entries (power of two, at least 2)
- TAG_W, 5, ROB tag width (matches alias-table tag width)
- XLEN, 32, operand and data width
- OP_W, 4, ALU opcode width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept (count < DEPTH)
- disp_op  in  OP_W  ALU opcode
- disp_rob_tag  in  TAG_W  destination ROB tag
- disp_rs1_pending  in  1  source 1 awaits a tag (alias-table valid)
- disp_rs1_tag  in  TAG_W  producer tag for source 1
- disp_rs1_val  in  XLEN  source 1 value when not pending
- disp_rs2_pending  in  1  as above, source 2 (immediates dispatch with pending=0)
- disp_rs2_tag  in  TAG_W  producer tag for source 2
- disp_rs2_val  in  XLEN  source 2 value when not pending
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB broadcast tag
- cdb_data  in  XLEN  CDB broadcast result
- issue_valid  out  1  a ready entry is presented
- issue_ready  in  1  ALU accepts
- issue_op  out  OP_W  opcode of presented entry
- issue_rob_tag  out  TAG_W  destination tag of presented entry
- issue_a  out  XLEN  operand 1 of presented entry
- issue_b  out  XLEN  operand 2 of presented entry
- count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Entry state: busy, op, rob_tag, per source {pending, tag, value}, age (clog2(DEPTH) bits).
- Reset (rst_n low, asynchronous): all busy=0, count=0, issue_valid=0, disp_ready=1. issue_op/rob_tag/a/b=0 when issue_valid=0.
- Dispatch fires on disp_valid && disp_ready; data is written into the lowest-index free entry at the clock edge.
- Dispatch-cycle bypass: if a source is pending and cdb_valid && cdb_tag equals its tag in the dispatch cycle, store pending=0 and value=cdb_data.
- Wakeup: every cycle with cdb_valid, each busy entry source that is pending with a matching tag clears pending and latches cdb_data. Both sources of one entry may wake in the same cycle.
- Ready: busy && !rs1.pending && !rs2.pending, evaluated on registered state. An entry dispatched ready, or woken at edge N, is issuable in the cycle after edge N (1-cycle wakeup-to-issue latency).
- Select: combinational; picks the ready entry with the smallest age (oldest). issue_valid = any ready. issue_* reflect the selected entry.
- Issue fires on issue_valid && issue_ready:
  - selected entry freed at the edge;
  - entries with age greater than the issued age decrement by 1.
- Age on dispatch: new entry age = count after this cycle's issue removal (youngest). Ages of busy entries are always a dense 0..count-1.
- issue_* must be held stable while issue_valid && !issue_ready, unless a strictly older entry becomes ready. Select may change; no buffering is required.
- Simultaneous dispatch and issue in the same cycle:
  - both take effect;
  - count unchanged;
  - disp_ready is not increased by the same-cycle issue.
- Full: count == DEPTH gives disp_ready=0. A disp_valid while full is ignored with no state change.
- flush (synchronous) takes priority over dispatch, wakeup and issue:
  - all busy cleared, count=0 next cycle;
  - issue_valid=0 from the next cycle;
  - a handshake in the flush cycle still reaches the ALU, and downstream discards it.
- Reset asserted mid-operation clears everything immediately, regardless of clock.
- A CDB tag matching no pending source is ignored. Tag compare covers the full TAG_W bits.

Test Plan:
- Reset then dispatch op=3, tag=7, rs1 val=10, rs2 val=20, both ready, with issue_ready=1 -> issue_valid=1 the next cycle with op=3, rob_tag=7, a=10, b=20; count returns to 0.
- Dispatch with rs1 pending tag=5 and rs2 ready; hold 3 cycles; then cdb_valid tag=5 data=0xDEADBEEF -> no issue before the CDB edge; issue_a=0xDEADBEEF in the cycle after.
- Dispatch rs1 pending tag=9 in the same cycle as cdb_valid tag=9 data=42 -> entry stored ready; issues the next cycle with a=42.
- Fill 4 entries (tags 1..4), all pending on tag 12, issue_ready=0 -> disp_ready=0 and a 5th dispatch is ignored. Then CDB tag=12 and issue_ready=1 -> issues in order 1,2,3,4 on consecutive cycles.
- Entries tag 1 (pending tag 20) and tag 2 (ready); issue tag 2; wake tag 1; dispatch tag 3 ready in the same cycle tag 1 issues -> order 2,1,3; count never exceeds 2.
- With 3 busy entries, assert flush together with a dispatch -> count=0 and issue_valid=0 next cycle. Separately, drop rst_n mid-cycle -> outputs reset with no clock edge.

Source files
------------

// File: rtl/rs_alu.sv
// Integer ALU reservation station: captures CDB results and issues the oldest ready entry.
// Wakeup-to-issue takes 1 cycle; dispatch stalls at full and issue holds while issue_ready is low.
module rs_alu #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32,
  parameter int OP_W  = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [TAG_W-1:0] disp_rob_tag,
  input  logic             disp_rs1_pending,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic [XLEN-1:0]  disp_rs1_val,
  input  logic             disp_rs2_pending,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic [XLEN-1:0]  disp_rs2_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [OP_W-1:0]  issue_op,
  output logic [TAG_W-1:0] issue_rob_tag,
  output logic [XLEN-1:0]  issue_a,
  output logic [XLEN-1:0]  issue_b,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic             pending;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } src_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] rob_tag;
    src_t             rs1;
    src_t             rs2;
    logic [IDX_W-1:0] age;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] rdy;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx, sel_age, free_idx, new_age;
  logic             disp_fire, issue_fire;
  src_t             disp_s1, disp_s2;

  // Full-width tag match against the CDB; a hit clears pending and takes the broadcast value.
  function automatic src_t capture(input src_t s, input logic hit_en, input logic [TAG_W-1:0] tag,
                                   input logic [XLEN-1:0] data);
    src_t r;
    r = s;
    if (s.pending && hit_en && (s.tag == tag)) begin
      r.pending = 1'b0;
      r.val     = data;
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = ent_q[i].busy && !ent_q[i].rs1.pending && !ent_q[i].rs2.pending;
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && (!sel_found || (ent_q[i].age < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = ent_q[i].age;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) free_idx = IDX_W'(i);
    end
  end

  assign disp_ready  = (count_q < CNT_W'(DEPTH));
  assign disp_fire   = disp_valid && disp_ready;
  assign issue_valid = sel_found;
  assign issue_fire  = issue_valid && issue_ready;
  assign count       = count_q;
  // The newcomer is youngest among what remains after this cycle's issue.
  assign new_age     = IDX_W'(count_q - CNT_W'(issue_fire));

  always_comb begin
    disp_s1 = capture('{pending: disp_rs1_pending, tag: disp_rs1_tag, val: disp_rs1_val},
                      cdb_valid, cdb_tag, cdb_data);
    disp_s2 = capture('{pending: disp_rs2_pending, tag: disp_rs2_tag, val: disp_rs2_val},
                      cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy) begin
        ent_d[i].rs1 = capture(ent_q[i].rs1, cdb_valid, cdb_tag, cdb_data);
        ent_d[i].rs2 = capture(ent_q[i].rs2, cdb_valid, cdb_tag, cdb_data);
        if (issue_fire && (IDX_W'(i) == sel_idx)) begin
          ent_d[i].busy = 1'b0;
        end else if (issue_fire && (ent_q[i].age > sel_age)) begin
          ent_d[i].age = ent_q[i].age - 1'b1;
        end
      end
    end
    if (disp_fire) begin
      ent_d[free_idx].busy    = 1'b1;
      ent_d[free_idx].op      = disp_op;
      ent_d[free_idx].rob_tag = disp_rob_tag;
      ent_d[free_idx].rs1     = disp_s1;
      ent_d[free_idx].rs2     = disp_s2;
      ent_d[free_idx].age     = new_age;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
    end
  end

  always_comb begin
    if (flush) count_d = '0;
    else       count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

  always_comb begin
    issue_op      = '0;
    issue_rob_tag = '0;
    issue_a       = '0;
    issue_b       = '0;
    if (sel_found) begin
      issue_op      = ent_q[sel_idx].op;
      issue_rob_tag = ent_q[sel_idx].rob_tag;
      issue_a       = ent_q[sel_idx].rs1.val;
      issue_b       = ent_q[sel_idx].rs2.val;
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: directed dispatch/CDB vectors, monitor checks each issue handshake.
module tb_rs_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_op;
  logic [4:0]  disp_rob_tag;
  logic        disp_rs1_pending;
  logic [4:0]  disp_rs1_tag;
  logic [31:0] disp_rs1_val;
  logic        disp_rs2_pending;
  logic [4:0]  disp_rs2_tag;
  logic [31:0] disp_rs2_val;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [4:0]  issue_rob_tag;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [2:0]  count;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  rs_alu #(.DEPTH(4), .TAG_W(5), .XLEN(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_rob_tag(disp_rob_tag),
    .disp_rs1_pending(disp_rs1_pending), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_val(disp_rs1_val),
    .disp_rs2_pending(disp_rs2_pending), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_val(disp_rs2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rob_tag(issue_rob_tag), .issue_a(issue_a), .issue_b(issue_b), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && issue_valid && issue_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got tag %0d op %0d a %0h b %0h, expected nothing",
                 issue_rob_tag, issue_op, issue_a, issue_b);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({issue_op, issue_rob_tag, issue_a, issue_b} !== e) begin
          errors++;
          $display("FAIL issue_data: got op %0d tag %0d a %0h b %0h, expected op %0d tag %0d a %0h b %0h",
                   issue_op, issue_rob_tag, issue_a, issue_b, e.op, e.tag, e.a, e.b);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic disp_one(input logic [3:0] op, input logic [4:0] tag,
                          input logic p1, input logic [4:0] t1, input logic [31:0] v1,
                          input logic p2, input logic [4:0] t2, input logic [31:0] v2);
    disp_valid = 1'b1; disp_op = op; disp_rob_tag = tag;
    disp_rs1_pending = p1; disp_rs1_tag = t1; disp_rs1_val = v1;
    disp_rs2_pending = p2; disp_rs2_tag = t2; disp_rs2_val = v2;
    tick();
    disp_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_rob_tag = '0;
    disp_rs1_pending = 1'b0; disp_rs1_tag = '0; disp_rs1_val = '0;
    disp_rs2_pending = 1'b0; disp_rs2_tag = '0; disp_rs2_val = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    #12 rst_n = 1'b1;

    chk("reset_count", 64'(count), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);
    chk("reset_issue_a", 64'(issue_a), 64'd0);

    // Both operands ready: issuable the cycle after dispatch.
    issue_ready = 1'b1;
    exp_q.push_back('{op: 4'd3, tag: 5'd7, a: 32'd10, b: 32'd20});
    disp_one(4'd3, 5'd7, 1'b0, 5'd0, 32'd10, 1'b0, 5'd0, 32'd20);
    chk("t1_issue_valid", 64'(issue_valid), 64'd1);
    chk("t1_count_busy", 64'(count), 64'd1);
    tick();
    chk("t1_count_drained", 64'(count), 64'd0);

    // rs1 waits on tag 5 across three idle cycles.
    exp_q.push_back('{op: 4'd1, tag: 5'd8, a: 32'hDEADBEEF, b: 32'd3});
    disp_one(4'd1, 5'd8, 1'b1, 5'd5, 32'd0, 1'b0, 5'd0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_no_issue", 64'(issue_valid), 64'd0);
      tick();
    end
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_data = 32'hDEADBEEF;
    chk("t2_cdb_cycle_no_issue", 64'(issue_valid), 64'd0);
    tick();
    cdb_valid = 1'b0;
    chk("t2_wake_issue_valid", 64'(issue_valid), 64'd1);
    chk("t2_wake_issue_a", 64'(issue_a), 64'hDEADBEEF);
    tick();

    // Dispatch-cycle bypass from the CDB.
    exp_q.push_back('{op: 4'd2, tag: 5'd10, a: 32'd42, b: 32'd1});
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'd42;
    disp_one(4'd2, 5'd10, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 32'd1);
    cdb_valid = 1'b0;
    chk("t3_bypass_issue_valid", 64'(issue_valid), 64'd1);
    chk("t3_bypass_issue_a", 64'(issue_a), 64'd42);
    tick();
    chk("t3_count_drained", 64'(count), 64'd0);

    // Fill, reject a fifth dispatch, then drain oldest-first.
    issue_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back('{op: 4'd4, tag: 5'(i), a: 32'd100, b: 32'(i)});
      disp_one(4'd4, 5'(i), 1'b1, 5'd12, 32'd0, 1'b0, 5'd0, 32'(i));
    end
    chk("t4_full_count", 64'(count), 64'd4);
    chk("t4_full_disp_ready", 64'(disp_ready), 64'd0);
    disp_one(4'd9, 5'd5, 1'b0, 5'd0, 32'd77, 1'b0, 5'd0, 32'd88);
    chk("t4_ignored_count", 64'(count), 64'd4);
    chk("t4_ignored_no_issue", 64'(issue_valid), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd12; cdb_data = 32'd100;
    tick();
    cdb_valid = 1'b0;
    issue_ready = 1'b1;
    chk("t4_first_tag", 64'(issue_rob_tag), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_drained_count", 64'(count), 64'd0);
    chk("t4_drained_valid", 64'(issue_valid), 64'd0);

    // Younger ready entry issues first; then wake, issue, and dispatch together.
    issue_ready = 1'b0;
    disp_one(4'd5, 5'd1, 1'b1, 5'd20, 32'd0, 1'b0, 5'd0, 32'd7);
    disp_one(4'd6, 5'd2, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd2);
    chk("t5_count_two", 64'(count), 64'd2);
    chk("t5_sel_tag2", 64'(issue_rob_tag), 64'd2);
    exp_q.push_back('{op: 4'd6, tag: 5'd2, a: 32'd1, b: 32'd2});
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_data = 32'd55;
    chk("t5_pending_no_issue", 64'(issue_valid), 64'd0);
    tick();
    cdb_valid = 1'b0;
    issue_ready = 1'b1;
    chk("t5_tag1_ready", 64'(issue_rob_tag), 64'd1);
    exp_q.push_back('{op: 4'd5, tag: 5'd1, a: 32'd55, b: 32'd7});
    exp_q.push_back('{op: 4'd7, tag: 5'd3, a: 32'h11, b: 32'h22});
    disp_one(4'd7, 5'd3, 1'b0, 5'd0, 32'h11, 1'b0, 5'd0, 32'h22);
    chk("t5_count_after_swap", 64'(count), 64'd1);
    tick();
    chk("t5_count_final", 64'(count), 64'd0);

    // Flush wins over a same-cycle dispatch.
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) disp_one(4'd8, 5'(16 + i), 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd2);
    chk("t6_count_three", 64'(count), 64'd3);
    flush = 1'b1;
    disp_one(4'd8, 5'd30, 1'b0, 5'd0, 32'd3, 1'b0, 5'd0, 32'd4);
    flush = 1'b0;
    chk("t6_flush_count", 64'(count), 64'd0);
    chk("t6_flush_issue_valid", 64'(issue_valid), 64'd0);
    chk("t6_flush_disp_ready", 64'(disp_ready), 64'd1);

    // Asynchronous reset between clock edges.
    disp_one(4'd11, 5'd21, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd6);
    chk("t7_pre_reset_valid", 64'(issue_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_issue_valid", 64'(issue_valid), 64'd0);
    chk("t7_async_count", 64'(count), 64'd0);
    chk("t7_async_issue_op", 64'(issue_op), 64'd0);
    chk("t7_async_disp_ready", 64'(disp_ready), 64'd1);
    rst_n = 1'b1;
    tick();
    tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
